// File: rtl/interval_timer.sv
// Interval timer: 16-bit down-counter driven by an 8-bit prescaler, with a small
// CPU register file and a level interrupt. All state advances on the falling edge of clk.
module interval_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] i_data,
    output logic [7:0] o_data,
    input  logic [2:0] addr,
    input  logic       cs,
    input  logic       rwb,
    output logic       irq
);

    localparam logic [2:0] ADDR_CTRL      = 3'd0;
    localparam logic [2:0] ADDR_STATUS    = 3'd1;
    localparam logic [2:0] ADDR_RELOAD_LO = 3'd2;
    localparam logic [2:0] ADDR_RELOAD_HI = 3'd3;
    localparam logic [2:0] ADDR_COUNT_LO  = 3'd4;
    localparam logic [2:0] ADDR_COUNT_HI  = 3'd5;
    localparam logic [2:0] ADDR_PRESCALE  = 3'd6;

    logic        r_en;
    logic        r_oneshot;
    logic        r_ie;
    logic        r_if;
    logic [15:0] r_reload;
    logic [7:0]  r_prescale;
    logic [15:0] r_count;
    logic [7:0]  r_pcnt;
    logic [7:0]  r_count_hi;

    logic        w_en_next;
    logic        w_oneshot_next;
    logic        w_ie_next;
    logic        w_if_next;
    logic [15:0] w_reload_next;
    logic [7:0]  w_prescale_next;
    logic [15:0] w_count_next;
    logic [7:0]  w_pcnt_next;
    logic [7:0]  w_count_hi_next;

    logic        w_wr;
    logic        w_rd;
    logic        w_ctrl_wr;
    logic        w_status_wr;
    logic        w_reload_lo_wr;
    logic        w_reload_hi_wr;
    logic        w_prescale_wr;
    logic        w_count_lo_rd;
    logic        w_load;
    logic        w_tick;
    logic        w_expire;

    assign w_wr           = cs & ~rwb;
    assign w_rd           = cs & rwb;
    assign w_ctrl_wr      = w_wr && (addr == ADDR_CTRL);
    assign w_status_wr    = w_wr && (addr == ADDR_STATUS);
    assign w_reload_lo_wr = w_wr && (addr == ADDR_RELOAD_LO);
    assign w_reload_hi_wr = w_wr && (addr == ADDR_RELOAD_HI);
    assign w_prescale_wr  = w_wr && (addr == ADDR_PRESCALE);
    assign w_count_lo_rd  = w_rd && (addr == ADDR_COUNT_LO);

    // Only a 0->1 transition of EN restarts the period; rewriting EN=1 keeps counting.
    assign w_load = w_ctrl_wr & i_data[0] & ~r_en;

    // Counting is gated by the EN value held before this edge, so a CTRL write
    // landing on an expiry edge still sees that expiry.
    always_comb begin
        w_pcnt_next  = r_pcnt;
        w_count_next = r_count;
        w_tick       = 1'b0;
        w_expire     = 1'b0;
        if (w_load) begin
            w_count_next = r_reload;
            w_pcnt_next  = r_prescale;
        end else if (r_en) begin
            if (r_pcnt != 8'd0) begin
                w_pcnt_next = r_pcnt - 8'd1;
            end else begin
                w_pcnt_next = r_prescale;
                w_tick      = 1'b1;
            end
            if (w_tick) begin
                if (r_count != 16'd0) begin
                    w_count_next = r_count - 16'd1;
                end else begin
                    w_count_next = r_reload;
                    w_expire     = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_en_next       = r_en;
        w_oneshot_next  = r_oneshot;
        w_ie_next       = r_ie;
        w_if_next       = r_if;
        w_reload_next   = r_reload;
        w_prescale_next = r_prescale;
        w_count_hi_next = r_count_hi;

        // An explicit CTRL write overrides the one-shot auto-disable.
        if (w_ctrl_wr) begin
            w_en_next      = i_data[0];
            w_oneshot_next = i_data[1];
            w_ie_next      = i_data[2];
        end else if (w_expire && r_oneshot) begin
            w_en_next = 1'b0;
        end

        // Expiry beats a simultaneous clear so no interrupt is lost.
        if (w_expire) begin
            w_if_next = 1'b1;
        end else if (w_status_wr && i_data[0]) begin
            w_if_next = 1'b0;
        end

        if (w_reload_lo_wr) begin
            w_reload_next[7:0] = i_data;
        end
        if (w_reload_hi_wr) begin
            w_reload_next[15:8] = i_data;
        end
        if (w_prescale_wr) begin
            w_prescale_next = i_data;
        end

        // Snapshot the high byte when the low byte is read so a 16-bit read is coherent.
        if (w_count_lo_rd) begin
            w_count_hi_next = r_count[15:8];
        end
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            r_en       <= 1'b0;
            r_oneshot  <= 1'b0;
            r_ie       <= 1'b0;
            r_if       <= 1'b0;
            r_reload   <= 16'd0;
            r_prescale <= 8'd0;
            r_count    <= 16'd0;
            r_pcnt     <= 8'd0;
            r_count_hi <= 8'd0;
        end else begin
            r_en       <= w_en_next;
            r_oneshot  <= w_oneshot_next;
            r_ie       <= w_ie_next;
            r_if       <= w_if_next;
            r_reload   <= w_reload_next;
            r_prescale <= w_prescale_next;
            r_count    <= w_count_next;
            r_pcnt     <= w_pcnt_next;
            r_count_hi <= w_count_hi_next;
        end
    end

    always_comb begin
        o_data = 8'h00;
        if (w_rd) begin
            case (addr)
                ADDR_CTRL:      o_data = {5'b0, r_ie, r_oneshot, r_en};
                ADDR_STATUS:    o_data = {6'b0, r_en, r_if};
                ADDR_RELOAD_LO: o_data = r_reload[7:0];
                ADDR_RELOAD_HI: o_data = r_reload[15:8];
                ADDR_COUNT_LO:  o_data = r_count[7:0];
                ADDR_COUNT_HI:  o_data = r_count_hi;
                ADDR_PRESCALE:  o_data = r_prescale;
                default:        o_data = 8'h00;
            endcase
        end
    end

    assign irq = r_if & r_ie;

endmodule

// File: tb/tb_interval_timer.sv
// Self-checking bench for interval_timer: randomized periods against an arithmetic
// model of count/expiry timing, plus directed corner scenarios.
module tb_interval_timer;

    logic       clk = 1'b1;
    logic       reset;
    logic [7:0] i_data;
    logic [7:0] o_data;
    logic [2:0] addr;
    logic       cs;
    logic       rwb;
    logic       irq;

    int total = 0;
    int bad   = 0;

    localparam logic [2:0] A_CTRL      = 3'd0;
    localparam logic [2:0] A_STATUS    = 3'd1;
    localparam logic [2:0] A_RELOAD_LO = 3'd2;
    localparam logic [2:0] A_RELOAD_HI = 3'd3;
    localparam logic [2:0] A_COUNT_LO  = 3'd4;
    localparam logic [2:0] A_COUNT_HI  = 3'd5;
    localparam logic [2:0] A_PRESCALE  = 3'd6;
    localparam logic [2:0] A_UNUSED    = 3'd7;

    interval_timer dut (
        .clk   (clk),
        .reset (reset),
        .i_data(i_data),
        .o_data(o_data),
        .addr  (addr),
        .cs    (cs),
        .rwb   (rwb),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    // Count value after t falling edges since the enabling edge: one tick every
    // (P+1) edges, and the counter cycles R, R-1, ..., 0, R, ...
    function automatic int exp_count(input int r, input int p, input int t);
        int j;
        j = t / (p + 1);
        return r - (j % (r + 1));
    endfunction

    function automatic bit is_expiry(input int r, input int p, input int t);
        return (t > 0) && ((t % ((r + 1) * (p + 1))) == 0);
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        cs     = 1'b0;
        rwb    = 1'b1;
        addr   = 3'd0;
        i_data = 8'h00;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        cs     = 1'b1;
        rwb    = 1'b0;
        addr   = a;
        i_data = d;
        step();
        idle();
    endtask

    task automatic rd(input logic [2:0] a);
        cs   = 1'b1;
        rwb  = 1'b1;
        addr = a;
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic setup_timer(input int r, input int p);
        logic [15:0] rv;
        logic [7:0]  pv;
        rv = 16'(r);
        pv = 8'(p);
        do_reset();
        wr(A_RELOAD_LO, rv[7:0]);
        wr(A_RELOAD_HI, rv[15:8]);
        wr(A_PRESCALE, pv);
    endtask

    task automatic test_reset();
        do_reset();
        for (int a = 0; a < 8; a++) begin
            rd(3'(a));
            total++;
            if (o_data !== 8'h00) begin
                bad++;
                $display("FAIL reset_read addr=%0d got=%h want=00", a, o_data);
            end
            idle();
            step();
        end
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL reset_irq got=%b want=0", irq);
        end
    endtask

    task automatic test_regs();
        logic [7:0] rl, rh, ps, v;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            rl = 8'($urandom);
            rh = 8'($urandom);
            ps = 8'($urandom);
            v  = 8'($urandom);
            wr(A_RELOAD_LO, rl);
            wr(A_RELOAD_HI, rh);
            wr(A_PRESCALE, ps);
            wr(A_UNUSED, 8'($urandom));
            wr(A_CTRL, v);
            rd(A_RELOAD_LO); total++;
            if (o_data !== rl) begin bad++; $display("FAIL regs_reload_lo got=%h want=%h", o_data, rl); end
            rd(A_RELOAD_HI); total++;
            if (o_data !== rh) begin bad++; $display("FAIL regs_reload_hi got=%h want=%h", o_data, rh); end
            rd(A_PRESCALE); total++;
            if (o_data !== ps) begin bad++; $display("FAIL regs_prescale got=%h want=%h", o_data, ps); end
            rd(A_UNUSED); total++;
            if (o_data !== 8'h00) begin bad++; $display("FAIL regs_addr7 got=%h want=00", o_data); end
            rd(A_CTRL); total++;
            if (o_data !== {5'b0, v[2:0]}) begin bad++; $display("FAIL regs_ctrl got=%h want=%h", o_data, {5'b0, v[2:0]}); end
            idle();
            step();
        end
        // Output must be zero unless a read is selected
        wr(A_CTRL, 8'h07);
        cs = 1'b0; rwb = 1'b1; addr = A_CTRL; #1;
        total++;
        if (o_data !== 8'h00) begin bad++; $display("FAIL regs_no_cs got=%h want=00", o_data); end
        cs = 1'b1; rwb = 1'b0; addr = A_PRESCALE; i_data = 8'h00; #1;
        total++;
        if (o_data !== 8'h00) begin bad++; $display("FAIL regs_write_cycle got=%h want=00", o_data); end
        idle();
        step();
    endtask

    task automatic test_periodic_random();
        for (int it = 0; it < 6; it++) begin
            int r, p, per, n, ph;
            logic [15:0] c;
            logic [7:0]  hi_m;
            bit          if_m;
            if (it == 0) begin
                r = 3; p = 1;
            end else if (it == 1) begin
                r = 0; p = 0;
            end else if ((it % 2) == 1) begin
                r = int'($urandom_range(0, 6)); p = int'($urandom_range(0, 3));
            end else begin
                r = int'($urandom_range(250, 270)); p = int'($urandom_range(0, 2));
            end
            per = (r + 1) * (p + 1);
            n   = 2 * per + 6;
            setup_timer(r, p);
            wr(A_CTRL, 8'h05);
            if_m = 1'b0;
            hi_m = 8'h00;
            for (int t = 1; t <= n; t++) begin
                ph = t % 3;
                if (ph == 1) begin
                    rd(A_COUNT_LO);
                    c = 16'(exp_count(r, p, t - 1));
                    hi_m = c[15:8];
                    total++;
                    if (o_data !== c[7:0]) begin
                        bad++;
                        $display("FAIL periodic_count_lo r=%0d p=%0d t=%0d got=%h want=%h", r, p, t, o_data, c[7:0]);
                    end
                end else if (ph == 2) begin
                    rd(A_COUNT_HI);
                    total++;
                    if (o_data !== hi_m) begin
                        bad++;
                        $display("FAIL periodic_count_hi r=%0d p=%0d t=%0d got=%h want=%h", r, p, t, o_data, hi_m);
                    end
                end else begin
                    cs = 1'b1; rwb = 1'b0; addr = A_STATUS; i_data = 8'h01; #1;
                end
                total++;
                if (irq !== if_m) begin
                    bad++;
                    $display("FAIL periodic_irq r=%0d p=%0d t=%0d got=%b want=%b", r, p, t, irq, if_m);
                end
                step();
                idle();
                if (is_expiry(r, p, t)) if_m = 1'b1;
                else if (ph == 0) if_m = 1'b0;
            end
        end
    endtask

    task automatic test_oneshot();
        logic [7:0] want;
        setup_timer(2, 0);
        wr(A_CTRL, 8'h07);
        for (int t = 1; t <= 10; t++) begin
            want = {6'b0, (t - 1 < 3), (t - 1 >= 3)};
            rd(A_STATUS);
            total++;
            if (o_data !== want) begin bad++; $display("FAIL oneshot_status t=%0d got=%h want=%h", t, o_data, want); end
            total++;
            if (irq !== want[0]) begin bad++; $display("FAIL oneshot_irq t=%0d got=%b want=%b", t, irq, want[0]); end
            step();
            idle();
        end
        rd(A_COUNT_LO); total++;
        if (o_data !== 8'h02) begin bad++; $display("FAIL oneshot_count got=%h want=02", o_data); end
        rd(A_CTRL); total++;
        if (o_data !== 8'h06) begin bad++; $display("FAIL oneshot_ctrl got=%h want=06", o_data); end
        idle();
        step();
    endtask

    task automatic test_oneshot_ctrl_collision();
        setup_timer(1, 0);
        wr(A_CTRL, 8'h03);
        step();
        wr(A_CTRL, 8'h03);
        rd(A_STATUS); total++;
        if (o_data !== 8'h03) begin bad++; $display("FAIL collide_ctrl_wins got=%h want=03", o_data); end
        step();
        idle();
        step();
        rd(A_STATUS); total++;
        if (o_data !== 8'h01) begin bad++; $display("FAIL collide_next_oneshot got=%h want=01", o_data); end
        rd(A_CTRL); total++;
        if (o_data !== 8'h02) begin bad++; $display("FAIL collide_ctrl_read got=%h want=02", o_data); end
        idle();
        step();
    endtask

    task automatic test_clear_collision();
        setup_timer(0, 0);
        wr(A_CTRL, 8'h05);
        wr(A_STATUS, 8'h01);
        total++;
        if (irq !== 1'b1) begin bad++; $display("FAIL clear_set_wins_irq got=%b want=1", irq); end
        rd(A_STATUS); total++;
        if (o_data !== 8'h03) begin bad++; $display("FAIL clear_set_wins_status got=%h want=03", o_data); end
        step();
        idle();
        wr(A_CTRL, 8'h00);
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL clear_ie_off_irq got=%b want=0", irq); end
        rd(A_STATUS); total++;
        if (o_data !== 8'h01) begin bad++; $display("FAIL clear_ie_off_status got=%h want=01", o_data); end
        step();
        idle();
        wr(A_CTRL, 8'h04);
        total++;
        if (irq !== 1'b1) begin bad++; $display("FAIL clear_ie_on_irq got=%b want=1", irq); end
        wr(A_STATUS, 8'h01);
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL clear_later_irq got=%b want=0", irq); end
        rd(A_STATUS); total++;
        if (o_data !== 8'h00) begin bad++; $display("FAIL clear_later_status got=%h want=00", o_data); end
        idle();
        step();
    endtask

    task automatic test_freeze();
        logic [15:0] c;
        setup_timer(10, 2);
        wr(A_CTRL, 8'h05);
        for (int t = 1; t <= 6; t++) step();
        wr(A_CTRL, 8'h04);
        c = 16'(exp_count(10, 2, 7));
        rd(A_COUNT_LO); total++;
        if (o_data !== c[7:0]) begin bad++; $display("FAIL freeze_first got=%h want=%h", o_data, c[7:0]); end
        idle();
        for (int t = 0; t < 5; t++) step();
        rd(A_COUNT_LO); total++;
        if (o_data !== c[7:0]) begin bad++; $display("FAIL freeze_hold got=%h want=%h", o_data, c[7:0]); end
        rd(A_STATUS); total++;
        if (o_data !== 8'h00) begin bad++; $display("FAIL freeze_status got=%h want=00", o_data); end
        idle();
        step();
        wr(A_CTRL, 8'h05);
        for (int t = 1; t <= 3; t++) step();
        wr(A_CTRL, 8'h07);
        for (int t = 5; t <= 7; t++) step();
        c = 16'(exp_count(10, 2, 7));
        rd(A_COUNT_LO); total++;
        if (o_data !== c[7:0]) begin bad++; $display("FAIL rewrite_en_no_reload got=%h want=%h", o_data, c[7:0]); end
        rd(A_CTRL); total++;
        if (o_data !== 8'h07) begin bad++; $display("FAIL rewrite_en_ctrl got=%h want=07", o_data); end
        idle();
        step();
    endtask

    task automatic test_reload_midcount();
        int  e1, e2;
        bit  if_m;
        setup_timer(16'h00FF, 0);
        wr(A_CTRL, 8'h05);
        e1   = 16'h00FF + 1;
        e2   = e1 + 16'h0010 + 1;
        if_m = 1'b0;
        for (int t = 1; t <= e2 + 3; t++) begin
            if (t == 10) begin
                cs = 1'b1; rwb = 1'b0; addr = A_RELOAD_LO; i_data = 8'h10;
            end else if (t == e1 + 1) begin
                cs = 1'b1; rwb = 1'b0; addr = A_STATUS; i_data = 8'h01;
            end else if (t == e1 + 2) begin
                cs = 1'b1; rwb = 1'b1; addr = A_COUNT_LO;
            end
            #1;
            if (t == e1 + 2) begin
                total++;
                if (o_data !== 8'h0F) begin bad++; $display("FAIL midcount_new_period got=%h want=0f", o_data); end
            end
            total++;
            if (irq !== if_m) begin bad++; $display("FAIL midcount_irq t=%0d got=%b want=%b", t, irq, if_m); end
            step();
            idle();
            if (t == e1 || t == e2) if_m = 1'b1;
            else if (t == e1 + 1) if_m = 1'b0;
        end
    endtask

    task automatic test_shadow();
        logic [15:0] c;
        setup_timer(16'h1234, 0);
        wr(A_CTRL, 8'h01);
        for (int t = 1; t <= 16'h34; t++) step();
        c = 16'(exp_count(16'h1234, 0, 16'h34));
        rd(A_COUNT_LO); total++;
        if (o_data !== c[7:0]) begin bad++; $display("FAIL shadow_lo got=%h want=%h", o_data, c[7:0]); end
        step();
        idle();
        step();
        step();
        rd(A_COUNT_HI); total++;
        if (o_data !== c[15:8]) begin bad++; $display("FAIL shadow_hi got=%h want=%h", o_data, c[15:8]); end
        step();
        c = 16'(exp_count(16'h1234, 0, 16'h38));
        rd(A_COUNT_LO); total++;
        if (o_data !== c[7:0]) begin bad++; $display("FAIL shadow_lo2 got=%h want=%h", o_data, c[7:0]); end
        step();
        rd(A_COUNT_HI); total++;
        if (o_data !== c[15:8]) begin bad++; $display("FAIL shadow_hi2 got=%h want=%h", o_data, c[15:8]); end
        idle();
        step();
    endtask

    task automatic test_reset_midcount();
        setup_timer(0, 0);
        wr(A_CTRL, 8'h05);
        step();
        step();
        total++;
        if (irq !== 1'b1) begin bad++; $display("FAIL midreset_pre_irq got=%b want=1", irq); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL midreset_irq got=%b want=0", irq); end
        for (int a = 0; a < 8; a++) begin
            rd(3'(a));
            total++;
            if (o_data !== 8'h00) begin bad++; $display("FAIL midreset_read addr=%0d got=%h want=00", a, o_data); end
            idle();
            step();
        end
        for (int t = 0; t < 5; t++) begin
            rd(A_STATUS);
            total++;
            if (o_data !== 8'h00 || irq !== 1'b0) begin
                bad++;
                $display("FAIL midreset_idle t=%0d status=%h irq=%b want 00/0", t, o_data, irq);
            end
            idle();
            step();
        end
    endtask

    initial begin
        reset  = 1'b1;
        idle();
        test_reset();
        test_regs();
        test_periodic_random();
        test_oneshot();
        test_oneshot_ctrl_collision();
        test_clear_collision();
        test_freeze();
        test_reload_midcount();
        test_shadow();
        test_reset_midcount();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
